// File: rtl/sipo_latch_driver.sv
// Serial-in, parallel-out front end that assembles MSB-first bits into a word and
// sequences D/E for a downstream level-sensitive latch bank (setup, strobe, hold).
module sipo_latch_driver #(
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             e_out,
    output logic             word_done
);

    localparam int BCW = $clog2(WIDTH);
    localparam int SCW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [SCW-1:0] STB_LAST = SCW'(EN_CYCLES - 1);

    typedef enum logic [1:0] {SHIFT, SETUP, STROBE, HOLD} state_t;

    state_t             state, state_n;
    logic [BCW-1:0]     bitcnt, bitcnt_n;
    logic [SCW-1:0]     scnt, scnt_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [WIDTH-1:0]   d_out_n;
    logic               accept;

    assign din_ready = (state == SHIFT) && !rst;
    assign accept    = din_valid && din_ready;

    // Next-state logic; d_out is only ever reloaded on the edge that enters SETUP.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        scnt_n   = scnt;
        shreg_n  = shreg;
        d_out_n  = d_out;
        case (state)
            SHIFT: begin
                if (accept) begin
                    shreg_n = {shreg[WIDTH-2:0], din};
                    if (bitcnt == BIT_LAST) begin
                        bitcnt_n = '0;
                        d_out_n  = shreg_n;
                        state_n  = SETUP;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
            end
            SETUP: begin
                scnt_n  = '0;
                state_n = STROBE;
            end
            STROBE: begin
                if (scnt == STB_LAST) begin
                    scnt_n  = '0;
                    state_n = HOLD;
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            HOLD:    state_n = SHIFT;
            default: state_n = SHIFT;
        endcase
    end

    // e_out and word_done are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHIFT;
            bitcnt    <= '0;
            scnt      <= '0;
            shreg     <= '0;
            d_out     <= '0;
            e_out     <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            scnt      <= scnt_n;
            shreg     <= shreg_n;
            d_out     <= d_out_n;
            e_out     <= (state_n == STROBE);
            word_done <= (state_n == STROBE) && (scnt_n == STB_LAST);
        end
    end

endmodule
